// File: rtl/sobel_ctrl_pkg.sv
// Shared types and constants for the sobel job sequencer.
package sobel_ctrl_pkg;

  // Sequencer states; encoding is visible on the fsm_state debug output.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_IDLE = 3'd1,
    S_START     = 3'd2,
    S_RUN       = 3'd3,
    S_FLUSH     = 3'd4,
    S_REPORT    = 3'd5
  } state_t;

  // Completion status codes carried in done_status.
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  // Number of cycles the core is held in reset when a job is killed.
  localparam int FLUSH_CYC = 2;

endpackage

// File: rtl/sobel_job_fifo.sv
// Synchronous job FIFO. A push while full is dropped even if a pop happens
// in the same cycle, so "full" depends only on the registered count.
module sobel_job_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sobel_run_ctrl.sv
// Job sequencer for the sobel core: queues jobs, drives the ap_* handshake,
// enforces a run-time watchdog, flushes a hung core and reports each job.
//
// Handshakes: job_valid/job_ready and done_valid/done_ready transfer on a
// clock edge where both are high; a producer holds valid and its payload
// stable until that edge, and valid never waits on ready.
module sobel_run_ctrl
  import sobel_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int QDEPTH  = 4,
  parameter int CNT_W   = 20,
  parameter int TIMEOUT = 2**20-1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W-1:0] job_in_base,
  input  logic [ADDR_W-1:0] job_out_base,
  input  logic              abort,
  output logic              core_rst,
  output logic              core_ap_start,
  input  logic              core_ap_ready,
  input  logic              core_ap_done,
  input  logic              core_ap_idle,
  output logic [ADDR_W-1:0] core_in_base,
  output logic [ADDR_W-1:0] core_out_base,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [1:0]        done_status,
  output logic [CNT_W-1:0]  done_cycles,
  output logic              busy,
  output logic [15:0]       jobs_ok,
  output logic [2:0]        fsm_state
);

  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state, state_n;
  logic                pop;
  logic                q_full, q_empty;
  logic [2*ADDR_W-1:0] q_data;
  logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc;
  logic                timeout_hit;
  logic [1:0]          flush_cnt, flush_n;
  logic                rec_load;
  logic [1:0]          rec_status, rec_status_n;
  logic [CNT_W-1:0]    rec_cycles, rec_cycles_n;
  logic                ok_inc;
  logic                ready_en;
  logic                core_rst_q;

  sobel_job_fifo #(
    .WIDTH (2*ADDR_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .push      (job_valid && job_ready),
    .push_data ({job_in_base, job_out_base}),
    .pop       (pop),
    .pop_data  (q_data),
    .full      (q_full),
    .empty     (q_empty)
  );

  // The cycle count saturates; the watchdog fires on the cycle it reaches the limit.
  assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign timeout_hit = (cnt_inc >= TO_LIM);

  // Outputs are decodes of registers only; ready_en keeps job_ready low in reset.
  assign job_ready     = ready_en && !q_full;
  assign core_ap_start = (state == S_START);
  assign done_valid    = (state == S_REPORT);
  assign core_rst      = core_rst_q;
  assign busy          = (state != S_IDLE) || !q_empty;
  assign done_status   = rec_status;
  assign done_cycles   = rec_cycles;
  assign fsm_state     = state;

  // Next-state logic; done beats abort, abort beats the watchdog.
  always_comb begin
    state_n      = state;
    pop          = 1'b0;
    cnt_n        = cnt;
    flush_n      = '0;
    rec_load     = 1'b0;
    rec_status_n = ST_OK;
    rec_cycles_n = cnt_inc;
    ok_inc       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          cnt_n   = '0;
          state_n = core_ap_idle ? S_START : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        // Time spent waiting is watched but not reported as run cycles.
        cnt_n        = cnt_inc;
        rec_cycles_n = '0;
        if (abort) begin
          state_n      = S_FLUSH;
          rec_load     = 1'b1;
          rec_status_n = ST_ABORT;
        end else if (timeout_hit) begin
          state_n      = S_FLUSH;
          rec_load     = 1'b1;
          rec_status_n = ST_TIMEOUT;
        end else if (core_ap_idle) begin
          state_n = S_START;
          cnt_n   = '0;
        end
      end
      S_START: begin
        cnt_n = cnt_inc;
        if (core_ap_ready && core_ap_done) begin
          state_n  = S_REPORT;
          rec_load = 1'b1;
        end else if (abort) begin
          state_n      = S_FLUSH;
          rec_load     = 1'b1;
          rec_status_n = ST_ABORT;
        end else if (timeout_hit) begin
          state_n      = S_FLUSH;
          rec_load     = 1'b1;
          rec_status_n = ST_TIMEOUT;
        end else if (core_ap_ready) begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        cnt_n = cnt_inc;
        if (core_ap_done) begin
          state_n  = S_REPORT;
          rec_load = 1'b1;
        end else if (abort) begin
          state_n      = S_FLUSH;
          rec_load     = 1'b1;
          rec_status_n = ST_ABORT;
        end else if (timeout_hit) begin
          state_n      = S_FLUSH;
          rec_load     = 1'b1;
          rec_status_n = ST_TIMEOUT;
        end
      end
      S_FLUSH: begin
        if (flush_cnt == 2'(FLUSH_CYC - 1)) state_n = S_REPORT;
        else                                flush_n = flush_cnt + 2'd1;
      end
      S_REPORT: begin
        if (done_ready) begin
          state_n = S_IDLE;
          ok_inc  = (rec_status == ST_OK);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters, completion record and core reset register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      flush_cnt  <= '0;
      rec_status <= ST_OK;
      rec_cycles <= '0;
      jobs_ok    <= '0;
      ready_en   <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      flush_cnt  <= flush_n;
      ready_en   <= 1'b1;
      core_rst_q <= (state_n == S_FLUSH);
      if (rec_load) begin
        rec_status <= rec_status_n;
        rec_cycles <= rec_cycles_n;
      end
      if (ok_inc) jobs_ok <= jobs_ok + 16'd1;
    end
  end

  // Job bases are captured on pop and held until the next pop.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      core_in_base  <= '0;
      core_out_base <= '0;
    end else if (pop) begin
      core_in_base  <= q_data[2*ADDR_W-1:ADDR_W];
      core_out_base <= q_data[ADDR_W-1:0];
    end
  end

endmodule

// File: tb/tb_sobel_run_ctrl.sv
// Bench for sobel_run_ctrl: directed jobs, a reactive core model, and a
// scoreboard that checks each completion record against expected values.
module tb_sobel_run_ctrl;

  localparam int ADDR_W  = 18;
  localparam int QDEPTH  = 4;
  localparam int CNT_W   = 20;
  localparam int TIMEOUT = 100;
  localparam int W       = 2 + CNT_W + 2*ADDR_W;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] TMO = 2'b01;
  localparam logic [1:0] ABT = 2'b10;

  logic              ap_clk;
  logic              ap_rst_n;
  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W-1:0] job_in_base;
  logic [ADDR_W-1:0] job_out_base;
  logic              abort;
  logic              core_rst;
  logic              core_ap_start;
  logic              core_ap_ready;
  logic              core_ap_done;
  logic              core_ap_idle;
  logic [ADDR_W-1:0] core_in_base;
  logic [ADDR_W-1:0] core_out_base;
  logic              done_valid;
  logic              done_ready;
  logic [1:0]        done_status;
  logic [CNT_W-1:0]  done_cycles;
  logic              busy;
  logic [15:0]       jobs_ok;
  logic [2:0]        fsm_state;

  int checks;
  int errors;
  int exp_ok;
  logic idle_hold;

  logic [W-1:0] exp_q[$];
  int cfg_ready_q[$];
  int cfg_done_q[$];
  int cfg_abort_q[$];

  sobel_run_ctrl #(
    .ADDR_W  (ADDR_W),
    .QDEPTH  (QDEPTH),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .job_in_base   (job_in_base),
    .job_out_base  (job_out_base),
    .abort         (abort),
    .core_rst      (core_rst),
    .core_ap_start (core_ap_start),
    .core_ap_ready (core_ap_ready),
    .core_ap_done  (core_ap_done),
    .core_ap_idle  (core_ap_idle),
    .core_in_base  (core_in_base),
    .core_out_base (core_out_base),
    .done_valid    (done_valid),
    .done_ready    (done_ready),
    .done_status   (done_status),
    .done_cycles   (done_cycles),
    .busy          (busy),
    .jobs_ok       (jobs_ok),
    .fsm_state     (fsm_state)
  );

  // Clock and reset
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Driver: queue a job with its core-model behaviour and expected record.
  // rk/dk/ak are the cycle offsets from the first start cycle (k=0) at which
  // the model raises ready, done and abort (0 = never for done/abort).
  task automatic push_job(input logic [ADDR_W-1:0] ib, input logic [ADDR_W-1:0] ob,
                          input int rk, input int dk, input int ak,
                          input logic [1:0] st, input int cyc, input bit expect_rec);
    int guard;
    cfg_ready_q.push_back(rk);
    cfg_done_q.push_back(dk);
    cfg_abort_q.push_back(ak);
    if (expect_rec) exp_q.push_back({st, CNT_W'(cyc), ib, ob});
    job_valid    = 1'b1;
    job_in_base  = ib;
    job_out_base = ob;
    guard = 0;
    while (!job_ready && guard < 2000) begin
      tick();
      guard++;
    end
    if (!job_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=ready_low expected=ready_high");
    end
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < limit) begin
      tick();
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  // Core model: ready/done/abort timed from the first cycle it sees ap_start.
  initial begin : core_model
    int phase;
    int k;
    int rdy_k;
    int dn_k;
    int ab_k;
    phase = 0; k = 0; rdy_k = 1; dn_k = 1; ab_k = 0;
    core_ap_ready = 1'b0;
    core_ap_done  = 1'b0;
    core_ap_idle  = 1'b1;
    abort         = 1'b0;
    forever begin
      tick();
      core_ap_ready = 1'b0;
      core_ap_done  = 1'b0;
      abort         = 1'b0;
      if (core_rst) begin
        phase = 0;
      end else if (phase == 0) begin
        if (core_ap_start) begin
          phase = 1;
          k     = 0;
          if (cfg_ready_q.size() > 0) begin
            rdy_k = cfg_ready_q.pop_front();
            dn_k  = cfg_done_q.pop_front();
            ab_k  = cfg_abort_q.pop_front();
          end
        end
      end else if (dn_k != 0 && k == dn_k) begin
        phase = 0;
      end else begin
        k++;
      end
      if (phase == 1) begin
        if (k == rdy_k)              core_ap_ready = 1'b1;
        if (dn_k != 0 && k == dn_k)  core_ap_done  = 1'b1;
        if (ab_k != 0 && k == ab_k)  abort         = 1'b1;
      end
      core_ap_idle = (phase == 0) && !idle_hold;
    end
  end

  // Scoreboard monitor: records, jobs_ok and flush length, sampled on negedge.
  initial begin : monitor
    logic [W-1:0] e;
    int run;
    bit tail;
    exp_ok = 0; run = 0; tail = 1'b1;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        exp_ok = 0;
        run    = 0;
        tail   = 1'b1;
      end else begin
        if (core_rst) begin
          if (!tail) begin
            run++;
            check("flush_start_low", core_ap_start, 0);
          end
        end else begin
          tail = 1'b0;
          if (run != 0) begin
            check("flush_len", run, 2);
            run = 0;
          end
        end
        if (done_valid && done_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_record actual=status%0d_cycles%0d expected=none", done_status, done_cycles);
          end else begin
            e = exp_q.pop_front();
            check("rec_status",   done_status,   e[W-1 -: 2]);
            check("rec_cycles",   done_cycles,   e[W-3 -: CNT_W]);
            check("rec_in_base",  core_in_base,  e[2*ADDR_W-1 -: ADDR_W]);
            check("rec_out_base", core_out_base, e[ADDR_W-1:0]);
            check("jobs_ok_run",  jobs_ok,       exp_ok);
            if (e[W-1 -: 2] == OK) exp_ok++;
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin : stimulus
    int n;
    checks = 0; errors = 0;
    job_valid = 1'b0; job_in_base = '0; job_out_base = '0;
    done_ready = 1'b1; idle_hold = 1'b0; ap_rst_n = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_core_rst",  core_rst, 1);
    check("rst_start",     core_ap_start, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_job_ready", job_ready, 0);
    check("rst_busy",      busy, 0);
    check("rst_jobs_ok",   jobs_ok, 0);
    check("rst_record",    {done_status, done_cycles}, 0);
    check("rst_bases",     {core_in_base, core_out_base}, 0);
    check("rst_state",     fsm_state, 0);
    ap_rst_n = 1'b1;
    tick();
    check("rel_core_rst",  core_rst, 0);
    check("rel_job_ready", job_ready, 1);

    // Single job: pushed at edge T, start is high during the cycle ending at T+2.
    push_job(18'h00100, 18'h20000, 1, 51, 0, OK, 52, 1'b1);
    check("lat_start_T1",  core_ap_start, 0);
    tick();
    check("lat_start_T2",  core_ap_start, 1);
    check("lat_in_base",   core_in_base, 18'h00100);
    check("lat_out_base",  core_out_base, 18'h20000);
    wait_drain(300);
    check("single_jobs_ok", jobs_ok, 1);

    // Long job, then five short ones; the queue fills after the fourth.
    push_job(18'h01000, 18'h01800, 1, 61, 0, OK, 62, 1'b1);
    for (int i = 0; i < 5; i++) begin
      push_job(ADDR_W'(32'h02000 + i * 32'h10), ADDR_W'(32'h03000 + i * 32'h10), 1, 4, 0, OK, 5, 1'b1);
      if (i == 3) check("queue_full_ready", job_ready, 0);
    end
    wait_drain(1000);

    // Hung core hits the watchdog, then the next queued job runs normally.
    push_job(18'h04000, 18'h04400, 1, 0, 0, TMO, 100, 1'b1);
    push_job(18'h05000, 18'h05400, 1, 10, 0, OK, 11, 1'b1);
    wait_drain(1000);

    // Abort in RUN; abort together with done; ready and done together.
    push_job(18'h06000, 18'h06400, 1, 0, 11, ABT, 12, 1'b1);
    push_job(18'h07000, 18'h07400, 1, 20, 20, OK, 21, 1'b1);
    push_job(18'h08000, 18'h08400, 2, 2, 0, OK, 3, 1'b1);
    wait_drain(1000);

    // Core not idle: the job waits and does not start until idle returns.
    @(negedge ap_clk);
    idle_hold = 1'b1;
    tick();
    push_job(18'h09000, 18'h09400, 1, 6, 0, OK, 7, 1'b1);
    repeat (6) tick();
    check("wait_idle_state", fsm_state, 1);
    check("wait_idle_start", core_ap_start, 0);
    @(negedge ap_clk);
    idle_hold = 1'b0;
    wait_drain(300);

    // Record held while done_ready is low; the queued job must not start.
    done_ready = 1'b0;
    push_job(18'h0a000, 18'h0a400, 1, 5, 0, OK, 6, 1'b1);
    push_job(18'h0b000, 18'h0b400, 1, 5, 0, OK, 6, 1'b1);
    n = 0;
    while (!done_valid && n < 100) begin
      tick();
      n++;
    end
    check("hold_reached", done_valid, 1);
    for (int c = 0; c < 20; c++) begin
      check("hold_record", {done_valid, core_ap_start, done_status, done_cycles, core_in_base},
            {1'b1, 1'b0, OK, CNT_W'(6), 18'h0a000});
      tick();
    end
    done_ready = 1'b1;
    wait_drain(300);

    // Reset in the middle of RUN: job lost, core held in reset.
    push_job(18'h0c000, 18'h0c400, 1, 0, 0, OK, 0, 1'b0);
    repeat (12) tick();
    check("mid_state_run", fsm_state, 3);
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_core_rst",   core_rst, 1);
    check("mid_rst_done_valid", done_valid, 0);
    check("mid_rst_start",      core_ap_start, 0);
    check("mid_rst_busy",       busy, 0);
    repeat (2) tick();
    ap_rst_n = 1'b1;
    tick();
    check("mid_rel_job_ready", job_ready, 1);
    check("mid_rel_core_rst",  core_rst, 0);
    check("mid_rel_jobs_ok",   jobs_ok, 0);

    // Recovery job after the reset.
    push_job(18'h0d000, 18'h0d400, 1, 3, 0, OK, 4, 1'b1);
    wait_drain(300);
    check("final_jobs_ok", jobs_ok, 1);
    check("final_cfg_left", cfg_ready_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_run_ctrl.md
# sobel_run_ctrl

Job sequencer for the `sobel` accelerator core. It queues frame jobs given as input/output base addresses, starts the core through its `ap_start`/`ap_ready`/`ap_done`/`ap_idle` handshake, and holds the job's base addresses stable for the core's address adapter. It enforces a run-time watchdog, recovers a hung core through the core's active-high reset, and returns a completion record per job. It sits between the host-side job interface and the sobel core instance.

## Interface
Parameters:
- `ADDR_W`, 18: width of the frame base addresses.
- `QDEPTH`, 4: job queue depth (power of two, ≥2).
- `CNT_W`, 20: width of the cycle counter and watchdog.
- `TIMEOUT`, 2**20-1: run-cycle limit before a job is declared hung.

Ports:
- `ap_clk`  in  1  clock; the only clock.
- `ap_rst_n`  in  1  reset, asynchronous, active-low.
- `job_valid`  in  1  job offered.
- `job_ready`  out  1  queue can accept a job.
- `job_in_base`  in  ADDR_W  input frame base address.
- `job_out_base`  in  ADDR_W  output frame base address.
- `abort`  in  1  single-cycle request to kill the running job.
- `core_rst`  out  1  drives the core's `ap_rst`, active-high.
- `core_ap_start`  out  1  drives the core's `ap_start`.
- `core_ap_ready`, `core_ap_done`, `core_ap_idle`  in  1 each  from the core.
- `core_in_base`, `core_out_base`  out  ADDR_W  bases of the current job.
- `done_valid`  out  1  completion record valid.
- `done_ready`  in  1  completion record consumed.
- `done_status`  out  2  00 OK, 01 TIMEOUT, 10 ABORT.
- `done_cycles`  out  CNT_W  cycles from `core_ap_start` rise to end of run, saturating.
- `busy`  out  1  FSM not in IDLE, or queue not empty.
- `jobs_ok`  out  16  count of OK completions, wraps.

## Operation
- Queue: a FIFO of {in_base, out_base}.
  - Push when `job_valid && job_ready`.
  - `job_ready` = count < QDEPTH. There is no bypass: a push while full is refused even if a pop happens in the same cycle.
- FSM states: IDLE, WAIT_IDLE, START, RUN, FLUSH, REPORT.
- IDLE: if the queue is non-empty, pop and load `core_in_base`/`core_out_base`. Go to START if `core_ap_idle`, else WAIT_IDLE.
- WAIT_IDLE: stay until `core_ap_idle`, then go to START. The watchdog runs here too.
- START: `core_ap_start`=1, held until `core_ap_ready` is sampled high.
  - On ready → RUN.
  - If `core_ap_done` is high in the same cycle as ready → REPORT with OK.
- RUN: `core_ap_start`=0. `core_ap_done` → REPORT with OK.
- Watchdog: the cycle counter clears on entry to START and increments each cycle in START and RUN.
  - When the counter reaches TIMEOUT → FLUSH with TIMEOUT.
  - `abort` sampled in WAIT_IDLE, START or RUN → FLUSH with ABORT.
  - `abort` in IDLE, FLUSH or REPORT is ignored.
  - If `abort` and `core_ap_done` occur in the same cycle, `core_ap_done` wins (status OK).
- FLUSH: `core_rst`=1 and `core_ap_start`=0 for exactly 2 cycles, then → REPORT.
- REPORT: `done_valid`=1 with `done_status`/`done_cycles` held stable until `done_ready`.
  - On the handshake: → IDLE, and `jobs_ok`++ if the status is OK.
  - The next job cannot start before the record is consumed.
- `core_in_base`/`core_out_base` do not change from the pop until the next pop.

## Timing
- Reset values (while `ap_rst_n`=0):
  - `core_rst`=1; it deasserts on the first `ap_clk` edge after release.
  - All other outputs are 0. The queue is empty and the FSM is in IDLE.
- Reset mid-job: the job is lost and no completion record is produced. The core is held in reset until release.
- Latency: job pushed at edge T with the queue empty and the FSM in IDLE gives pop at T+1 and `core_ap_start`=1 at T+2, provided the core is idle.
- `core_ap_done` sampled at edge D makes `done_valid`=1 after edge D, i.e. in cycle D+1.
- `done_cycles` = number of START and RUN cycles, saturating at 2^CNT_W−1.
- All outputs are registered. There are no combinational paths from inputs to outputs except `job_ready`, which depends on the registered count.

## Structure
- Package `sobel_ctrl_pkg`:
  - FSM state enum.
  - `done_status` codes: ST_OK, ST_TIMEOUT, ST_ABORT.
  - Flush length constant FLUSH_CYC=2.
- Sub-module `sobel_job_fifo`: parameterised synchronous FIFO (ADDR_W*2 wide, QDEPTH deep), with its own count and the same asynchronous active-low reset.
- The top level holds the FSM, the watchdog/cycle counter and the completion register.

## Test plan
- Single job in_base=0x00100, out_base=0x20000; core model pulses ready at start+1 and done 50 cycles later → `core_ap_start` high 2 cycles after push, `core_in_base`=0x00100, record OK with `done_cycles`=52, `jobs_ok`=1.
- Push 5 jobs back-to-back with QDEPTH=4 while the FSM is busy → `job_ready` low after the 4th queued entry; all 5 complete in order with matching bases.
- Core never asserts done, TIMEOUT=100 → `core_rst` high for 2 cycles, record TIMEOUT with `done_cycles`=100; the next queued job then runs OK.
- `abort` 10 cycles into RUN → FLUSH, then ABORT record; `abort` and `core_ap_done` in the same cycle → OK record.
- Hold `done_ready`=0 for 20 cycles → record fields stable and no new `core_ap_start`; assert `ap_rst_n`=0 mid-RUN → `core_rst`=1 and `done_valid`=0 immediately, `job_ready`=1 after release.
